// File: rtl/fme_halfpel_win_if.sv
// Request/result handshake and reference-window read port for fme_halfpel_win.
interface fme_halfpel_win_if #(
  parameter int PIX_W = 8,
  parameter int REF_W = 16,
  parameter int REF_H = 16
);
  localparam int XW = $clog2(REF_W);
  localparam int YW = $clog2(REF_H);
  localparam int AW = $clog2(REF_W * REF_H);

  logic               start;
  logic [XW-1:0]      cx;
  logic [YW-1:0]      cy;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [PIX_W-1:0]   rd_data;
  logic               busy;
  logic               done;
  logic [9*PIX_W-1:0] half;

  modport master (
    output start, cx, cy, rd_data,
    input  rd_en, rd_addr, busy, done, half
  );

  modport slave (
    input  start, cx, cy, rd_data,
    output rd_en, rd_addr, busy, done, half
  );
endinterface

// File: rtl/fme_halfpel_win.sv
// Half-pel interpolator: fetches a clamped 7x7 patch around (cx,cy) and produces
// the 3x3 grid of half-pel samples with the 6-tap (1,-5,20,20,-5,1) filter.
module fme_halfpel_win #(
  parameter int PIX_W = 8,
  parameter int REF_W = 16,
  parameter int REF_H = 16
) (
  input  logic             clk,
  input  logic             rst,
  fme_halfpel_win_if.slave bus
);
  localparam int XW = $clog2(REF_W);
  localparam int YW = $clog2(REF_H);
  localparam int AW = $clog2(REF_W * REF_H);
  localparam int HW = PIX_W + 7;
  localparam int VW = PIX_W + 13;
  localparam logic signed [VW-1:0] RND5  = VW'(16);
  localparam logic signed [VW-1:0] RND10 = VW'(512);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_FWAIT, S_HFILT, S_VFILT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic                    accept;
  logic                    rd_en_c, busy_c, done_c;
  logic [AW-1:0]           addr_c;
  logic [5:0]              k;
  logic [2:0]              fr, fc;
  logic [XW-1:0]           cx_q;
  logic [YW-1:0]           cy_q;
  logic                    prev_en;
  logic [5:0]              prev_k;
  logic [PIX_W-1:0]        patch [49];
  logic signed [HW-1:0]    hl [7];
  logic signed [HW-1:0]    hr [7];
  logic signed [VW-1:0]    hl_c, hr_c;
  logic [5:0]              rb;
  logic [9*PIX_W-1:0]      res_c;
  logic [9*PIX_W-1:0]      half_q;

  function automatic logic signed [VW-1:0] ext_p(input logic [PIX_W-1:0] p);
    return {{(VW-PIX_W){1'b0}}, p};
  endfunction

  function automatic logic signed [VW-1:0] tap6(
    input logic signed [VW-1:0] a, b, c, d, e, f
  );
    logic signed [VW-1:0] be, cd;
    be = b + e;
    cd = c + d;
    return a + f - ((be <<< 2) + be) + ((cd <<< 4) + (cd <<< 2));
  endfunction

  function automatic logic [PIX_W-1:0] sat(input logic signed [VW-1:0] v);
    if (v[VW-1])             return '0;
    else if (|v[VW-2:PIX_W]) return '1;
    else                     return v[PIX_W-1:0];
  endfunction

  assign accept = ((state == S_IDLE) || (state == S_DONE)) && bus.start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_en_c  = 1'b0;
    busy_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      S_IDLE:  if (accept) state_nx = S_FETCH;
      S_FETCH: begin
        rd_en_c = 1'b1;
        busy_c  = 1'b1;
        if (k == 6'd48) state_nx = S_FWAIT;
      end
      S_FWAIT: begin
        busy_c   = 1'b1;
        state_nx = S_HFILT;
      end
      S_HFILT: begin
        busy_c = 1'b1;
        if (fr == 3'd6) state_nx = S_VFILT;
      end
      S_VFILT: begin
        busy_c   = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done_c   = 1'b1;
        state_nx = accept ? S_FETCH : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // fr/fc walk the patch during FETCH; fr is then reused as the HFILT row index
  always_ff @(posedge clk) begin
    if (accept) begin
      cx_q <= bus.cx;
      cy_q <= bus.cy;
      k    <= '0;
      fr   <= '0;
      fc   <= '0;
    end else if (state == S_FETCH) begin
      k <= k + 6'd1;
      if (fc == 3'd6) begin
        fc <= '0;
        fr <= fr + 3'd1;
      end else begin
        fc <= fc + 3'd1;
      end
    end else if (state == S_FWAIT) begin
      fr <= '0;
    end else if (state == S_HFILT) begin
      fr <= fr + 3'd1;
    end
  end

  always_comb begin
    int xi, yi;
    xi = int'(cx_q) + int'(fc) - 3;
    yi = int'(cy_q) + int'(fr) - 3;
    if (xi < 0)      xi = 0;
    if (xi > REF_W-1) xi = REF_W - 1;
    if (yi < 0)      yi = 0;
    if (yi > REF_H-1) yi = REF_H - 1;
    addr_c = '0;
    if (state == S_FETCH) addr_c = AW'(yi * REF_W + xi);
  end

  // Read data lands one cycle late, so it is filed under the previous cycle's index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_en <= 1'b0;
      prev_k  <= '0;
    end else begin
      prev_en <= rd_en_c;
      prev_k  <= k;
    end
  end

  always_ff @(posedge clk) begin
    if (prev_en) patch[prev_k] <= bus.rd_data;
  end

  always_comb begin
    rb   = 6'(int'(fr) * 7);
    hl_c = tap6(ext_p(patch[rb]),        ext_p(patch[rb + 6'd1]),
                ext_p(patch[rb + 6'd2]), ext_p(patch[rb + 6'd3]),
                ext_p(patch[rb + 6'd4]), ext_p(patch[rb + 6'd5]));
    hr_c = tap6(ext_p(patch[rb + 6'd1]), ext_p(patch[rb + 6'd2]),
                ext_p(patch[rb + 6'd3]), ext_p(patch[rb + 6'd4]),
                ext_p(patch[rb + 6'd5]), ext_p(patch[rb + 6'd6]));
  end

  always_ff @(posedge clk) begin
    if (state == S_HFILT) begin
      hl[fr] <= HW'(hl_c);
      hr[fr] <= HW'(hr_c);
    end
  end

  always_comb begin
    logic signed [VW-1:0] vl0, vl1, vr0, vr1, vc0, vc1;
    vl0 = tap6(VW'(hl[0]), VW'(hl[1]), VW'(hl[2]), VW'(hl[3]), VW'(hl[4]), VW'(hl[5]));
    vl1 = tap6(VW'(hl[1]), VW'(hl[2]), VW'(hl[3]), VW'(hl[4]), VW'(hl[5]), VW'(hl[6]));
    vr0 = tap6(VW'(hr[0]), VW'(hr[1]), VW'(hr[2]), VW'(hr[3]), VW'(hr[4]), VW'(hr[5]));
    vr1 = tap6(VW'(hr[1]), VW'(hr[2]), VW'(hr[3]), VW'(hr[4]), VW'(hr[5]), VW'(hr[6]));
    vc0 = tap6(ext_p(patch[3]),  ext_p(patch[10]), ext_p(patch[17]),
               ext_p(patch[24]), ext_p(patch[31]), ext_p(patch[38]));
    vc1 = tap6(ext_p(patch[10]), ext_p(patch[17]), ext_p(patch[24]),
               ext_p(patch[31]), ext_p(patch[38]), ext_p(patch[45]));
    res_c = '0;
    res_c[0*PIX_W +: PIX_W] = sat((vl0 + RND10) >>> 10);
    res_c[1*PIX_W +: PIX_W] = sat((vc0 + RND5) >>> 5);
    res_c[2*PIX_W +: PIX_W] = sat((vr0 + RND10) >>> 10);
    res_c[3*PIX_W +: PIX_W] = sat((VW'(hl[3]) + RND5) >>> 5);
    res_c[4*PIX_W +: PIX_W] = patch[24];
    res_c[5*PIX_W +: PIX_W] = sat((VW'(hr[3]) + RND5) >>> 5);
    res_c[6*PIX_W +: PIX_W] = sat((vl1 + RND10) >>> 10);
    res_c[7*PIX_W +: PIX_W] = sat((vc1 + RND5) >>> 5);
    res_c[8*PIX_W +: PIX_W] = sat((vr1 + RND10) >>> 10);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  half_q <= '0;
    else if (state == S_VFILT) half_q <= res_c;
  end

  assign bus.rd_en   = rd_en_c;
  assign bus.rd_addr = addr_c;
  assign bus.busy    = busy_c;
  assign bus.done    = done_c;
  assign bus.half    = half_q;
endmodule

// File: tb/tb_fme_halfpel_win.sv
// Scoreboard bench for fme_halfpel_win against an integer reference model.
module tb_fme_halfpel_win;
  localparam int PW   = 8;
  localparam int RW   = 16;
  localparam int RH   = 16;
  localparam int NPIX = RW * RH;
  localparam int XW   = $clog2(RW);
  localparam int YW   = $clog2(RH);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fme_halfpel_win_if #(.PIX_W(PW), .REF_W(RW), .REF_H(RH)) bus ();
  fme_halfpel_win #(.PIX_W(PW), .REF_W(RW), .REF_H(RH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic [PW-1:0] mem [NPIX];
  int tp [6] = '{1, -5, 20, 20, -5, 1};
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.rd_data <= bus.rd_en ? mem[bus.rd_addr] : PW'($urandom);
  end

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int px(int x, int y);
    return int'(mem[clampi(y, 0, RH-1) * RW + clampi(x, 0, RW-1)]);
  endfunction

  function automatic int hsum(int x, int y, int side);
    int s = 0;
    int base = (side == 0) ? x - 3 : x - 2;
    for (int i = 0; i < 6; i++) s += tp[i] * px(base + i, y);
    return s;
  endfunction

  function automatic int vpix(int x, int y, int side);
    int s = 0;
    int base = (side == 0) ? y - 3 : y - 2;
    for (int i = 0; i < 6; i++) s += tp[i] * px(x, base + i);
    return s;
  endfunction

  function automatic int vh(int x, int y, int hside, int vside);
    int s = 0;
    int base = (vside == 0) ? y - 3 : y - 2;
    for (int i = 0; i < 6; i++) s += tp[i] * hsum(x, base + i, hside);
    return s;
  endfunction

  function automatic int clipi(int v);
    return clampi(v, 0, (1 << PW) - 1);
  endfunction

  function automatic logic [9*PW-1:0] model(int x, int y);
    int r [9];
    logic [9*PW-1:0] o;
    r[0] = clipi((vh(x, y, 0, 0) + 512) >>> 10);
    r[1] = clipi((vpix(x, y, 0) + 16) >>> 5);
    r[2] = clipi((vh(x, y, 1, 0) + 512) >>> 10);
    r[3] = clipi((hsum(x, y, 0) + 16) >>> 5);
    r[4] = px(x, y);
    r[5] = clipi((hsum(x, y, 1) + 16) >>> 5);
    r[6] = clipi((vh(x, y, 0, 1) + 512) >>> 10);
    r[7] = clipi((vpix(x, y, 1) + 16) >>> 5);
    r[8] = clipi((vh(x, y, 1, 1) + 512) >>> 10);
    o = '0;
    for (int k = 0; k < 9; k++) o[k*PW +: PW] = PW'(r[k]);
    return o;
  endfunction

  function automatic int exp_addr(int x, int y, int k);
    return clampi(y - 3 + k / 7, 0, RH-1) * RW + clampi(x - 3 + k % 7, 0, RW-1);
  endfunction

  typedef struct packed {
    logic [9*PW-1:0] half;
    int done_cyc;
    int cx;
    int cy;
  } exp_t;

  exp_t sbq [$];
  logic [9*PW-1:0] hold_exp = '0;
  int rd_cnt = 0;

  // Issue side: a start seen with busy low is accepted at the next edge
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && bus.start && !bus.busy) begin
      e.half     = model(int'(bus.cx), int'(bus.cy));
      e.done_cyc = cyc + 59;
      e.cx       = int'(bus.cx);
      e.cy       = int'(bus.cy);
      sbq.push_back(e);
    end
  end

  // Monitor side
  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    int got;
    if (rst !== 1'b1) begin
      checks++;
      if (bus.rd_en || bus.rd_addr != '0 || bus.busy || bus.done || bus.half != '0) begin
        errors++;
        $display("FAIL reset_outputs rd_en=%0b rd_addr=%0d busy=%0b done=%0b half=%h required all 0",
                 bus.rd_en, bus.rd_addr, bus.busy, bus.done, bus.half);
      end
      sbq.delete();
      hold_exp = '0;
      rd_cnt   = 0;
    end else begin
      exp_busy = (sbq.size() > 0) && (cyc >= sbq[0].done_cyc - 58) && (cyc < sbq[0].done_cyc);
      checks++;
      if (bus.busy !== exp_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got %0b expected %0b", cyc, bus.busy, exp_busy);
      end
      if (bus.rd_en) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL rd_en_unexpected cyc=%0d got 1 expected 0", cyc);
        end else if (int'(bus.rd_addr) != exp_addr(sbq[0].cx, sbq[0].cy, rd_cnt)) begin
          errors++;
          $display("FAIL rd_addr k=%0d got %0d expected %0d", rd_cnt, bus.rd_addr,
                   exp_addr(sbq[0].cx, sbq[0].cy, rd_cnt));
        end
        rd_cnt++;
      end
      if (bus.done) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d got 1 expected 0", cyc);
        end else begin
          e = sbq.pop_front();
          if (cyc != e.done_cyc) begin
            errors++;
            $display("FAIL done_cycle got %0d expected %0d", cyc, e.done_cyc);
          end
          checks++;
          if (rd_cnt != 49) begin
            errors++;
            $display("FAIL rd_en_count got %0d expected 49", rd_cnt);
          end
          for (int k = 0; k < 9; k++) begin
            checks++;
            got = int'(bus.half[k*PW +: PW]);
            if (got != int'(e.half[k*PW +: PW])) begin
              errors++;
              $display("FAIL half[%0d] centre (%0d,%0d) got %0d expected %0d",
                       k, e.cx, e.cy, got, e.half[k*PW +: PW]);
            end
          end
          hold_exp = e.half;
        end
        rd_cnt = 0;
      end else begin
        checks++;
        if (bus.half !== hold_exp) begin
          errors++;
          $display("FAIL half_hold cyc=%0d got %h expected %h", cyc, bus.half, hold_exp);
        end
      end
    end
  end

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic start_req(int x, int y);
    @(posedge clk); #2;
    bus.start = 1'b1;
    bus.cx    = XW'(x);
    bus.cy    = YW'(y);
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(string name);
    bit got = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout got no done expected done within 150 cycles", name);
    end
  endtask

  function automatic int idx(int k);
    logic [9*PW-1:0] h;
    h = bus.half;
    return int'(h[k*PW +: PW]);
  endfunction

  initial begin
    bus.start = 1'b0;
    bus.cx    = '0;
    bus.cy    = '0;
    rst       = 1'b0;
    for (int i = 0; i < NPIX; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;

    for (int i = 0; i < NPIX; i++) mem[i] = PW'(100);
    start_req(8, 8);
    wait_done("const");
    for (int k = 0; k < 9; k++) chk("const_idx", idx(k), 100);

    for (int i = 0; i < NPIX; i++) mem[i] = PW'(10 * (i % RW));
    start_req(8, 8);
    wait_done("ramp");
    chk("ramp_idx0", idx(0), 75);
    chk("ramp_idx4", idx(4), 80);
    chk("ramp_idx8", idx(8), 85);
    start_req(0, 0);
    wait_done("ramp_corner");
    chk("ramp00_idx3", idx(3), 0);
    chk("ramp00_idx5", idx(5), 4);
    chk("ramp00_idx4", idx(4), 0);

    for (int i = 0; i < NPIX; i++) mem[i] = ((i % RW) == 8 || (i % RW) == 9) ? 8'd255 : 8'd0;
    start_req(8, 8);
    wait_done("edge");
    chk("edge_idx5", idx(5), 255);
    chk("edge_idx3", idx(3), 120);
    chk("edge_idx4", idx(4), 255);

    for (int t = 0; t < 10; t++) begin
      int x, y;
      for (int i = 0; i < NPIX; i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? 8'd255 :
                 ($urandom_range(0, 3) == 0) ? 8'd0 : PW'($urandom);
      x = (t == 0 || t == 2) ? 0 : (t == 1 || t == 3) ? RW - 1 : $urandom_range(0, RW - 1);
      y = (t == 0 || t == 3) ? 0 : (t == 1 || t == 2) ? RH - 1 : $urandom_range(0, RH - 1);
      start_req(x, y);
      wait_done("random");
    end

    // Back-to-back with start held high; cx/cy change while busy
    @(posedge clk); #2;
    bus.start = 1'b1;
    bus.cx    = XW'(4);
    bus.cy    = YW'(4);
    @(posedge clk); #2;
    bus.cx = XW'(10);
    bus.cy = YW'(10);
    wait_done("b2b_first");
    @(posedge clk); #2;
    bus.start = 1'b0;
    wait_done("b2b_second");

    // Start pulse mid-FETCH must be ignored
    start_req(5, 5);
    repeat (20) @(posedge clk);
    #2;
    bus.start = 1'b1;
    bus.cx    = XW'(1);
    bus.cy    = YW'(1);
    @(posedge clk); #2;
    bus.start = 1'b0;
    wait_done("midfetch");

    // Reset during FETCH aborts the request
    start_req(8, 8);
    repeat (29) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (80) @(negedge clk);
    start_req(3, 12);
    wait_done("after_reset");

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
